// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction-memory interface.
//
// Takes a big-endian byte stream  LEN_HI LEN_LO {INS_HI INS_LO} x N  over a
// valid/ready handshake. It writes the N 16-bit instructions to addresses
// 0..N-1 and then zero-fills addresses N..DEPTH-1 on back-to-back cycles.
// The processor is held until every one of the DEPTH words has been written.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_data/in_valid  stream byte and its valid flag
//   in_ready          loader accepts a byte on this edge (registered)
//   reload            one-cycle pulse; restarts a load from DONE or ERR
//   mem_we/addr/data  one instruction-memory write per pulse
//   cpu_hold          processor held while 1
//   done              image loaded and memory filled
//   error             length header exceeded DEPTH (sticky until reload/rst)
module prog_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, INS_HI, INS_LO, FILL, DONE, ERR
  } state_t;

  // Counter and length are one bit wider than the address so that
  // N == DEPTH and the final fill address compare without wrapping.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;
  localparam logic [16:0]     DEPTH_L = DEPTH[16:0];

  state_t              state, state_d;
  logic [7:0]          len_hi, len_hi_d;
  logic [7:0]          ins_hi, ins_hi_d;
  logic [ADDR_W:0]     n, n_d;
  logic [ADDR_W:0]     cnt, cnt_d;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [15:0]         mem_data_d;
  logic                in_ready_d, done_d, error_d;

  logic                accept;
  logic [16:0]         len_word;
  logic [ADDR_W:0]     cnt_inc;

  // Next-state and next-output logic; every output is a register fed from here
  always_comb begin
    state_d    = state;
    len_hi_d   = len_hi;
    ins_hi_d   = ins_hi;
    n_d        = n;
    cnt_d      = cnt;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr;
    mem_data_d = mem_data;

    accept   = in_valid && in_ready;
    len_word = {1'b0, len_hi, in_data};
    cnt_inc  = cnt + 1'b1;

    case (state)
      LEN_HI: if (accept) begin
        len_hi_d = in_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (accept) begin
        n_d   = len_word[ADDR_W:0];
        cnt_d = '0;
        if (len_word > DEPTH_L)   state_d = ERR;
        else if (len_word == '0)  state_d = FILL;
        else                      state_d = INS_HI;
      end
      INS_HI: if (accept) begin
        ins_hi_d = in_data;
        state_d  = INS_LO;
      end
      INS_LO: if (accept) begin
        mem_we_d   = 1'b1;
        mem_addr_d = cnt[ADDR_W-1:0];
        mem_data_d = {ins_hi, in_data};
        cnt_d      = cnt_inc;
        // Fill continues straight from address N on the next edge.
        if (cnt_inc == n) state_d = (n < DEPTH_C) ? FILL : DONE;
        else              state_d = INS_HI;
      end
      FILL: begin
        mem_we_d   = 1'b1;
        mem_addr_d = cnt[ADDR_W-1:0];
        mem_data_d = '0;
        cnt_d      = cnt_inc;
        if (cnt == LAST_C) state_d = DONE;
      end
      DONE, ERR: if (reload) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase

    in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                 (state_d == INS_HI) || (state_d == INS_LO);
    // Status flags rise one edge after entering DONE/ERR, so done follows the
    // last write by one cycle; a reload drops them on the same edge.
    done_d  = (state == DONE) && (state_d == DONE);
    error_d = (state == ERR)  && (state_d == ERR);
  end

  // Register stage: state, counters and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LEN_HI;
      len_hi   <= '0;
      ins_hi   <= '0;
      n        <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_d;
      len_hi   <= len_hi_d;
      ins_hi   <= ins_hi_d;
      n        <= n_d;
      cnt      <= cnt_d;
      in_ready <= in_ready_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_data <= mem_data_d;
      cpu_hold <= !done_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
// A byte-count based model predicts every output for each cycle; a few
// literal expectations pin the model on the basic image.
module tb_prog_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks bytes accepted, declared length and next write address.
  typedef enum {M_LOAD, M_FILL, M_DONE, M_ERR} mode_t;
  mode_t      m_mode;
  int         m_nbytes, m_len, m_w;
  logic [7:0] m_hb;
  bit         e_ready, e_we, e_done, e_err, e_hold;
  int         e_addr, e_data;

  int cyc = 0;
  int wr_count, last_we_cyc, done_cyc;
  int w0_addr, w0_data, w1_addr, w1_data;

  task automatic m_reset();
    m_mode = M_LOAD; m_nbytes = 0; m_len = 0; m_w = 0; m_hb = '0;
    e_ready = 0; e_we = 0; e_done = 0; e_err = 0; e_hold = 1;
    e_addr = 0; e_data = 0;
    wr_count = 0; last_we_cyc = -1; done_cyc = -1;
    w0_addr = -1; w0_data = -1; w1_addr = -1; w1_data = -1;
  endtask

  // Predict the outputs that the next rising edge will produce.
  task automatic predict();
    bit acc;
    mode_t pre;
    logic [7:0] b;
    pre = m_mode;
    acc = in_valid && e_ready;
    b   = in_data;
    e_we = 0;
    case (m_mode)
      M_LOAD: if (acc) begin
        if (m_nbytes == 0) m_hb = b;
        else if (m_nbytes == 1) begin
          m_len = 32'({m_hb, b});
          m_w   = 0;
          if (m_len > DEPTH)    m_mode = M_ERR;
          else if (m_len == 0)  m_mode = M_FILL;
        end else if (m_nbytes % 2 == 0) m_hb = b;
        else begin
          e_we = 1; e_addr = m_w; e_data = 32'({m_hb, b});
          m_w++;
          if (m_w == m_len) m_mode = (m_len < DEPTH) ? M_FILL : M_DONE;
        end
        m_nbytes++;
      end
      M_FILL: begin
        e_we = 1; e_addr = m_w; e_data = 0;
        m_w++;
        if (m_w == DEPTH) m_mode = M_DONE;
      end
      M_DONE, M_ERR: if (reload) begin
        m_mode = M_LOAD; m_nbytes = 0;
        wr_count = 0; last_we_cyc = -1; done_cyc = -1;
        w0_addr = -1; w0_data = -1; w1_addr = -1; w1_data = -1;
      end
      default: ;
    endcase
    e_ready = (m_mode == M_LOAD);
    e_done  = (pre == M_DONE) && (m_mode == M_DONE);
    e_err   = (pre == M_ERR) && (m_mode == M_ERR);
    e_hold  = !e_done;
  endtask

  // Compare process: every falling edge.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we",   32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 1);
        check("rst_done",     32'(done), 0);
        check("rst_error",    32'(error), 0);
        m_reset();
      end else begin
        check("in_ready", 32'(in_ready), 32'(e_ready));
        check("mem_we",   32'(mem_we), 32'(e_we));
        if (e_we) begin
          check("mem_addr", 32'(mem_addr), e_addr);
          check("mem_data", 32'(mem_data), e_data);
        end
        check("done",     32'(done), 32'(e_done));
        check("error",    32'(error), 32'(e_err));
        check("cpu_hold", 32'(cpu_hold), 32'(e_hold));
        if (mem_we === 1'b1) begin
          if (wr_count == 0) begin w0_addr = 32'(mem_addr); w0_data = 32'(mem_data); end
          if (wr_count == 1) begin w1_addr = 32'(mem_addr); w1_data = 32'(mem_data); end
          wr_count++;
          last_we_cyc = cyc;
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      end
      predict();
    end
  end

  // Stimulus helpers
  logic [7:0] q[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_data = b; in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("byte_accept_timeout", 32'(t >= 200), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reload();
    @(posedge clk); #1 reload = 1'b1;
    @(posedge clk); #1 reload = 1'b0;
  endtask

  // gap < 0 picks a random 0..2 gap per byte; reload pulses after byte reload_at.
  task automatic send_q(input int gap, input int reload_at, input int stop_after);
    for (int i = 0; i < q.size() && i < stop_after; i++) begin
      send_byte(q[i], (gap < 0) ? int'($urandom_range(2, 0)) : gap);
      if (i == reload_at) pulse_reload();
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    check({name, "_done_timeout"}, 32'(t >= 3000), 0);
    #2;
  endtask

  task automatic check_basic(input string name);
    check({name, "_w0_addr"}, w0_addr, 0);
    check({name, "_w0_data"}, w0_data, 32'h006F);
    check({name, "_w1_addr"}, w1_addr, 1);
    check({name, "_w1_data"}, w1_data, 32'h6F00);
    check({name, "_writes"}, wr_count, 1024);
    check({name, "_done_lag"}, done_cyc - last_we_cyc, 1);
    check({name, "_cpu_hold"}, 32'(cpu_hold), 0);
    check({name, "_error"}, 32'(error), 0);
  endtask

  task automatic basic_q();
    q = '{8'h00, 8'h02, 8'h00, 8'h6F, 8'h6F, 8'h00};
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; reload = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    basic_q(); send_q(0, -1, 9999); wait_done("basic"); check_basic("basic");
    pulse_reload();

    basic_q(); send_q(3, -1, 9999); wait_done("gaps"); check_basic("gaps");
    pulse_reload();

    q = '{8'h04, 8'h00};
    for (int i = 0; i < 2 * DEPTH; i++) q.push_back(8'($urandom));
    send_q(0, -1, 9999); wait_done("full");
    check("full_writes", wr_count, 1024);
    check("full_done_lag", done_cyc - last_we_cyc, 1);
    pulse_reload();

    q = '{8'h00, 8'h00}; send_q(1, -1, 9999); wait_done("zero");
    check("zero_writes", wr_count, 1024);
    check("zero_w0_addr", w0_addr, 0);
    check("zero_w0_data", w0_data, 0);
    check("zero_done_lag", done_cyc - last_we_cyc, 1);
    pulse_reload();

    q = '{8'h04, 8'h01}; send_q(0, -1, 9999);
    repeat (5) @(negedge clk);
    #2;
    check("bad_error", 32'(error), 1);
    check("bad_in_ready", 32'(in_ready), 0);
    check("bad_cpu_hold", 32'(cpu_hold), 1);
    check("bad_writes", wr_count, 0);
    pulse_reload();
    q = '{8'h00, 8'h01, 8'h12, 8'h34}; send_q(0, -1, 9999); wait_done("after_err");
    check("after_err_w0_data", w0_data, 32'h1234);
    check("after_err_writes", wr_count, 1024);
    check("after_err_error", 32'(error), 0);
    check("after_err_done", 32'(done), 1);
    pulse_reload();

    basic_q(); send_q(0, -1, 4); do_reset();
    basic_q(); send_q(0, -1, 9999); wait_done("rst_ins"); check_basic("rst_ins");
    pulse_reload();
    basic_q(); send_q(0, -1, 9999);
    repeat (30) @(posedge clk);
    do_reset();
    basic_q(); send_q(0, -1, 9999); wait_done("rst_fill"); check_basic("rst_fill");
    pulse_reload();

    basic_q(); send_q(1, 2, 9999);
    repeat (20) @(posedge clk);
    #1;
    pulse_reload();
    wait_done("reload_ign"); check_basic("reload_ign");
    pulse_reload();

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(40, 1));
      q = '{8'(n >> 8), 8'(n)};
      for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
      send_q(-1, int'($urandom_range(2 * n + 1, 0)), 9999);
      wait_done("rand");
      check("rand_writes", wr_count, 1024);
      pulse_reload();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
